// File: rtl/axi4_burst_master.sv
// ---------------------------------------------------------------------------
// axi4_burst_master
//   AXI4 initiator that turns one user command into one INCR read or write
//   burst. Only one transaction is in flight at a time. Write beats come from
//   a valid/ready user stream and read beats leave on another one. A
//   one-cycle done pulse reports the worst response seen.
//
// Ports
//   axi_aclk, axi_resetn     clock, asynchronous active-low reset
//   cmd_*                    command handshake (write flag, byte address,
//                            beats-1)
//   usr_w*                   user write-beat stream into the master
//   usr_r*                   user read-beat stream out of the master
//   done, done_resp          completion pulse and its worst response
//   axi_aw/w/b/ar/r*         AXI4 master interface
//
// State table
//   S_IDLE  | cmd_ready high, waiting for a command
//   S_WADDR | awvalid held until awready
//   S_WDATA | user write beats passed through to W, beat counter running
//   S_WRESP | bready high, waiting for the write response
//   S_RADDR | arvalid held until arready
//   S_RDATA | R beats passed through to the user stream, beat counter running
//   S_ERR   | burst would cross a 4 KB page; no bus activity
//   S_DONE  | done pulse; cmd_ready still low
// ---------------------------------------------------------------------------
module axi4_burst_master #(
   parameter int         ADDR_WIDTH = 32,
   parameter int         DATA_WIDTH = 32,
   parameter logic [7:0] AXI_ID     = 8'd0
) (
   input  logic                      axi_aclk,
   input  logic                      axi_resetn,

   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [7:0]                cmd_len,

   input  logic [DATA_WIDTH-1:0]     usr_wdata,
   input  logic                      usr_wvalid,
   output logic                      usr_wready,

   output logic [DATA_WIDTH-1:0]     usr_rdata,
   output logic                      usr_rvalid,
   output logic                      usr_rlast,
   input  logic                      usr_rready,

   output logic                      done,
   output logic [1:0]                done_resp,

   output logic [7:0]                axi_awid,
   output logic [ADDR_WIDTH-1:0]     axi_awaddr,
   output logic [7:0]                axi_awlen,
   output logic [2:0]                axi_awsize,
   output logic [1:0]                axi_awburst,
   output logic                      axi_awlock,
   output logic [3:0]                axi_awcache,
   output logic [2:0]                axi_awprot,
   output logic [3:0]                axi_awqos,
   output logic [3:0]                axi_awregion,
   output logic                      axi_awvalid,
   input  logic                      axi_awready,

   output logic [DATA_WIDTH-1:0]     axi_wdata,
   output logic [DATA_WIDTH/8-1:0]   axi_wstrb,
   output logic                      axi_wlast,
   output logic                      axi_wvalid,
   input  logic                      axi_wready,

   input  logic [7:0]                axi_bid,
   input  logic [1:0]                axi_bresp,
   input  logic                      axi_bvalid,
   output logic                      axi_bready,

   output logic [7:0]                axi_arid,
   output logic [ADDR_WIDTH-1:0]     axi_araddr,
   output logic [7:0]                axi_arlen,
   output logic [2:0]                axi_arsize,
   output logic [1:0]                axi_arburst,
   output logic                      axi_arlock,
   output logic [3:0]                axi_arcache,
   output logic [2:0]                axi_arprot,
   output logic [3:0]                axi_arqos,
   output logic [3:0]                axi_arregion,
   output logic                      axi_arvalid,
   input  logic                      axi_arready,

   input  logic [7:0]                axi_rid,
   input  logic [DATA_WIDTH-1:0]     axi_rdata,
   input  logic [1:0]                axi_rresp,
   input  logic                      axi_rlast,
   input  logic                      axi_rvalid,
   output logic                      axi_rready
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int SIZE  = $clog2(BYTES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WADDR,
      S_WDATA,
      S_WRESP,
      S_RADDR,
      S_RDATA,
      S_ERR,
      S_DONE
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [7:0]              len_q;
   logic [7:0]              cnt;
   logic [1:0]              rd_resp_max;
   logic                    rd_mismatch;

   logic [13:0]             span_end;
   logic                    crosses_4k;
   logic                    last_beat;
   logic                    w_hs;
   logic                    r_hs;
   logic                    rlast_bad;
   logic [1:0]              resp_next;

   // End offset of the burst within its page; 14 bits so it never wraps even
   // for 256 beats of 16 bytes starting at offset 0xFFF.
   assign span_end   = 14'(cmd_addr[11:0]) + ((14'(cmd_len) + 14'd1) << SIZE);
   assign crosses_4k = (span_end > 14'd4096);

   assign last_beat  = (cnt == len_q);

   // Constant AXI attributes.
   assign axi_awid     = AXI_ID;
   assign axi_awsize   = 3'(SIZE);
   assign axi_awburst  = 2'b01;
   assign axi_awlock   = 1'b0;
   assign axi_awcache  = 4'd0;
   assign axi_awprot   = 3'd0;
   assign axi_awqos    = 4'd0;
   assign axi_awregion = 4'd0;
   assign axi_arid     = AXI_ID;
   assign axi_arsize   = 3'(SIZE);
   assign axi_arburst  = 2'b01;
   assign axi_arlock   = 1'b0;
   assign axi_arcache  = 4'd0;
   assign axi_arprot   = 3'd0;
   assign axi_arqos    = 4'd0;
   assign axi_arregion = 4'd0;
   assign axi_wstrb    = '1;

   assign axi_awaddr = addr_q;
   assign axi_awlen  = len_q;
   assign axi_araddr = addr_q;
   assign axi_arlen  = len_q;

   // W and R are pure pass-through, qualified by state so nothing leaks onto
   // the bus outside the data phase (and everything drops with reset).
   assign axi_wdata  = usr_wdata;
   assign axi_wvalid = (state == S_WDATA) && usr_wvalid;
   assign usr_wready = (state == S_WDATA) && axi_wready;
   assign axi_wlast  = (state == S_WDATA) && last_beat;
   assign w_hs       = axi_wvalid && axi_wready;

   assign usr_rdata  = axi_rdata;
   assign usr_rvalid = (state == S_RDATA) && axi_rvalid;
   assign axi_rready = (state == S_RDATA) && usr_rready;
   assign usr_rlast  = usr_rvalid && last_beat;
   assign r_hs       = usr_rvalid && usr_rready;

   assign rlast_bad  = (axi_rlast != last_beat);
   assign resp_next  = (axi_rresp > rd_resp_max) ? axi_rresp : rd_resp_max;

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state       <= S_IDLE;
         cmd_ready   <= 1'b0;
         axi_awvalid <= 1'b0;
         axi_arvalid <= 1'b0;
         axi_bready  <= 1'b0;
         done        <= 1'b0;
         done_resp   <= 2'b00;
         cnt         <= 8'd0;
         addr_q      <= '0;
         len_q       <= 8'd0;
         rd_resp_max <= 2'b00;
         rd_mismatch <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_ready   <= 1'b0;
                  addr_q      <= cmd_addr;
                  len_q       <= cmd_len;
                  cnt         <= 8'd0;
                  done_resp   <= 2'b00;
                  rd_resp_max <= 2'b00;
                  rd_mismatch <= 1'b0;
                  if (crosses_4k) begin
                     state <= S_ERR;
                  end else if (cmd_write) begin
                     state       <= S_WADDR;
                     axi_awvalid <= 1'b1;
                  end else begin
                     state       <= S_RADDR;
                     axi_arvalid <= 1'b1;
                  end
               end else begin
                  // cmd_ready comes up one cycle after reset release.
                  cmd_ready <= 1'b1;
               end
            end

            S_WADDR: begin
               if (axi_awready) begin
                  axi_awvalid <= 1'b0;
                  state       <= S_WDATA;
               end
            end

            S_WDATA: begin
               if (w_hs) begin
                  if (last_beat) begin
                     axi_bready <= 1'b1;
                     state      <= S_WRESP;
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
            end

            S_WRESP: begin
               if (axi_bvalid) begin
                  axi_bready <= 1'b0;
                  done_resp  <= axi_bresp;
                  done       <= 1'b1;
                  state      <= S_DONE;
               end
            end

            S_RADDR: begin
               if (axi_arready) begin
                  axi_arvalid <= 1'b0;
                  state       <= S_RDATA;
               end
            end

            S_RDATA: begin
               if (r_hs) begin
                  if (last_beat) begin
                     // A framing error (rlast out of step with the count)
                     // overrides whatever the slave reported.
                     done_resp <= (rd_mismatch || rlast_bad) ? 2'b10 : resp_next;
                     done      <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     cnt         <= cnt + 8'd1;
                     rd_resp_max <= resp_next;
                     rd_mismatch <= rd_mismatch || rlast_bad;
                  end
               end
            end

            S_ERR: begin
               done_resp <= 2'b10;
               done      <= 1'b1;
               state     <= S_DONE;
            end

            S_DONE: begin
               cmd_ready <= 1'b1;
               state     <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // IDs are constant on this master, so the returned IDs carry no information.
   logic unused_ok;
   assign unused_ok = ^{axi_bid, axi_rid};

endmodule

// File: tb/tb_axi4_burst_master.sv
module tb_axi4_burst_master;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [7:0] ID = 8'h3C;

   logic            axi_aclk;
   logic            axi_resetn;
   logic            cmd_valid;
   logic            cmd_ready;
   logic            cmd_write;
   logic [AW-1:0]   cmd_addr;
   logic [7:0]      cmd_len;
   logic [DW-1:0]   usr_wdata;
   logic            usr_wvalid;
   logic            usr_wready;
   logic [DW-1:0]   usr_rdata;
   logic            usr_rvalid;
   logic            usr_rlast;
   logic            usr_rready;
   logic            done;
   logic [1:0]      done_resp;
   logic [7:0]      axi_awid;
   logic [AW-1:0]   axi_awaddr;
   logic [7:0]      axi_awlen;
   logic [2:0]      axi_awsize;
   logic [1:0]      axi_awburst;
   logic            axi_awlock;
   logic [3:0]      axi_awcache;
   logic [2:0]      axi_awprot;
   logic [3:0]      axi_awqos;
   logic [3:0]      axi_awregion;
   logic            axi_awvalid;
   logic            axi_awready;
   logic [DW-1:0]   axi_wdata;
   logic [DW/8-1:0] axi_wstrb;
   logic            axi_wlast;
   logic            axi_wvalid;
   logic            axi_wready;
   logic [7:0]      axi_bid;
   logic [1:0]      axi_bresp;
   logic            axi_bvalid;
   logic            axi_bready;
   logic [7:0]      axi_arid;
   logic [AW-1:0]   axi_araddr;
   logic [7:0]      axi_arlen;
   logic [2:0]      axi_arsize;
   logic [1:0]      axi_arburst;
   logic            axi_arlock;
   logic [3:0]      axi_arcache;
   logic [2:0]      axi_arprot;
   logic [3:0]      axi_arqos;
   logic [3:0]      axi_arregion;
   logic            axi_arvalid;
   logic            axi_arready;
   logic [7:0]      axi_rid;
   logic [DW-1:0]   axi_rdata;
   logic [1:0]      axi_rresp;
   logic            axi_rlast;
   logic            axi_rvalid;
   logic            axi_rready;

   axi4_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AXI_ID(ID)) dut (
      .axi_aclk(axi_aclk), .axi_resetn(axi_resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .usr_wdata(usr_wdata), .usr_wvalid(usr_wvalid), .usr_wready(usr_wready),
      .usr_rdata(usr_rdata), .usr_rvalid(usr_rvalid), .usr_rlast(usr_rlast),
      .usr_rready(usr_rready), .done(done), .done_resp(done_resp),
      .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
      .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
      .axi_awcache(axi_awcache), .axi_awprot(axi_awprot), .axi_awqos(axi_awqos),
      .axi_awregion(axi_awregion), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
      .axi_bready(axi_bready),
      .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
      .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
      .axi_arcache(axi_arcache), .axi_arprot(axi_arprot), .axi_arqos(axi_arqos),
      .axi_arregion(axi_arregion), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
      .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
   );

   initial axi_aclk = 1'b0;
   always #5 axi_aclk = ~axi_aclk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input int idx, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   // ---------------- stimulus knobs (written only by the initial block)
   int          aw_delay  = 0;
   bit          wv_toggle = 0;
   bit          stall_en  = 0;
   int          err_beat  = -1;
   logic [1:0]  err_resp  = 2'b00;
   int          bad_beat  = -1;
   logic [1:0]  b_resp    = 2'b00;
   logic [31:0] rd_base   = 32'h0;
   logic [31:0] wbase     = 32'h0;
   logic [7:0]  cur_len   = 8'd0;
   bit          mon_clr   = 1'b1;

   // ---------------- slave model
   int         aw_wait;
   logic       rd_active;
   logic [8:0] sbeat;
   logic [7:0] s_arlen;

   assign axi_awready = axi_awvalid && (aw_wait >= aw_delay);
   assign axi_wready  = 1'b1;
   assign axi_arready = axi_arvalid;
   assign axi_bid     = ID;
   assign axi_bresp   = b_resp;
   assign axi_rid     = ID;
   assign axi_rvalid  = rd_active;
   assign axi_rdata   = rd_base + 32'(sbeat);
   assign axi_rresp   = (int'(sbeat) == err_beat) ? err_resp : 2'b00;
   assign axi_rlast   = rd_active && ((sbeat == 9'(s_arlen)) ^ (int'(sbeat) == bad_beat));

   always @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) aw_wait <= 0;
      else if (axi_awvalid && !axi_awready) aw_wait <= aw_wait + 1;
      else aw_wait <= 0;
   end

   always @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) axi_bvalid <= 1'b0;
      else if (axi_wvalid && axi_wready && axi_wlast) axi_bvalid <= 1'b1;
      else if (axi_bvalid && axi_bready) axi_bvalid <= 1'b0;
   end

   always @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         rd_active <= 1'b0;
         sbeat     <= 9'd0;
         s_arlen   <= 8'd0;
      end else if (axi_arvalid && axi_arready) begin
         rd_active <= 1'b1;
         sbeat     <= 9'd0;
         s_arlen   <= axi_arlen;
      end else if (axi_rvalid && axi_rready) begin
         if (sbeat == 9'(s_arlen)) rd_active <= 1'b0;
         sbeat <= sbeat + 9'd1;
      end
   end

   // ---------------- user-side drivers
   int widx;
   int rcyc;

   assign usr_wdata  = wbase + 32'(widx);
   assign usr_rready = !(stall_en && (rcyc == 2 || rcyc == 3));

   always @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) usr_wvalid <= 1'b0;
      else usr_wvalid <= wv_toggle ? !usr_wvalid : 1'b1;
   end

   always @(posedge axi_aclk) begin
      if (mon_clr) widx <= 0;
      else if (usr_wvalid && usr_wready) widx <= widx + 1;
   end

   always @(posedge axi_aclk) begin
      if (mon_clr) rcyc <= 0;
      else if (axi_arvalid && axi_arready) rcyc <= 1;
      else if (rcyc != 0) rcyc <= rcyc + 1;
   end

   // ---------------- monitors
   bit          aw_seen;
   logic [31:0] cap_addr;
   logic [7:0]  cap_len;
   logic [28:0] cap_attr;
   int w_beats, r_beats, done_cnt, bus_cnt;
   int wdata_bad, wlast_bad, w_early, strb_bad, rdata_bad, rlast_bad, aw_drop;
   bit          aw_wait_prev;
   logic [31:0] aw_prev_addr;

   always @(posedge axi_aclk) begin
      if (mon_clr) begin
         aw_seen <= 1'b0; cap_addr <= '0; cap_len <= '0; cap_attr <= '0;
         w_beats <= 0; r_beats <= 0; done_cnt <= 0; bus_cnt <= 0;
         wdata_bad <= 0; wlast_bad <= 0; w_early <= 0; strb_bad <= 0;
         rdata_bad <= 0; rlast_bad <= 0; aw_drop <= 0;
         aw_wait_prev <= 1'b0; aw_prev_addr <= '0;
      end else begin
         if (axi_awvalid && axi_awready) begin
            aw_seen  <= 1'b1;
            cap_addr <= axi_awaddr;
            cap_len  <= axi_awlen;
            cap_attr <= {axi_awid, axi_awsize, axi_awburst, axi_awlock, axi_awcache,
                         axi_awprot, axi_awqos, axi_awregion};
         end
         if (axi_arvalid && axi_arready) begin
            cap_addr <= axi_araddr;
            cap_len  <= axi_arlen;
            cap_attr <= {axi_arid, axi_arsize, axi_arburst, axi_arlock, axi_arcache,
                         axi_arprot, axi_arqos, axi_arregion};
         end
         if (axi_wvalid && axi_wready) begin
            w_beats <= w_beats + 1;
            if (!aw_seen) w_early <= w_early + 1;
            if (axi_wdata !== wbase + 32'(w_beats)) wdata_bad <= wdata_bad + 1;
            if (axi_wlast !== (w_beats == int'(cur_len))) wlast_bad <= wlast_bad + 1;
            if (axi_wstrb !== 4'hF) strb_bad <= strb_bad + 1;
         end
         if (usr_rvalid && usr_rready) begin
            r_beats <= r_beats + 1;
            if (usr_rdata !== rd_base + 32'(r_beats)) rdata_bad <= rdata_bad + 1;
            if (usr_rlast !== (r_beats == int'(cur_len))) rlast_bad <= rlast_bad + 1;
         end
         if (done) done_cnt <= done_cnt + 1;
         if (axi_awvalid || axi_arvalid || axi_wvalid || axi_bready || axi_rready)
            bus_cnt <= bus_cnt + 1;
         if (aw_wait_prev && (!axi_awvalid || axi_awaddr !== aw_prev_addr))
            aw_drop <= aw_drop + 1;
         aw_wait_prev <= axi_awvalid && !axi_awready;
         aw_prev_addr <= axi_awaddr;
      end
   end

   // ---------------- vector table
   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [7:0]  len;
      bit          toggle;
      int          aw_delay;
      bit          stall;
      int          err_beat;
      logic [1:0]  err_resp;
      int          bad_beat;
      logic [1:0]  bresp;
      logic [31:0] rbase;
      logic [1:0]  exp_resp;
      int          exp_cycles;   // 0: not checked (data-dependent stalls)
      int          exp_beats;
      bit          exp_err;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   task automatic run_vec(input vec_t v, input int idx);
      int  t;
      int  cyc;
      bit  got;
      logic [1:0] resp;
      aw_delay  = v.aw_delay;
      wv_toggle = v.toggle;
      stall_en  = v.stall;
      err_beat  = v.err_beat;
      err_resp  = v.err_resp;
      bad_beat  = v.bad_beat;
      b_resp    = v.bresp;
      rd_base   = v.rbase;
      wbase     = 32'hA000_0000 + (32'(idx) << 16);
      cur_len   = v.len;
      @(negedge axi_aclk);
      mon_clr = 1'b1;
      @(negedge axi_aclk);
      mon_clr   = 1'b0;
      cmd_valid = 1'b1;
      cmd_write = v.wr;
      cmd_addr  = v.addr;
      cmd_len   = v.len;
      t = 0;
      while (!cmd_ready && t < 50) begin
         @(negedge axi_aclk);
         t++;
      end
      check("cmd_ready", idx, cmd_ready, 1);
      @(posedge axi_aclk);
      #1 cmd_valid = 1'b0;
      cyc  = 0;
      got  = 1'b0;
      resp = 2'b00;
      while (!got && cyc < 3000) begin
         @(negedge axi_aclk);
         cyc++;
         if (done) begin
            got  = 1'b1;
            resp = done_resp;
         end
      end
      check("done_seen", idx, got, 1);
      check("done_resp", idx, resp, v.exp_resp);
      if (v.exp_cycles != 0) check("latency", idx, cyc, v.exp_cycles);
      @(negedge axi_aclk);
      @(negedge axi_aclk);
      check("done_pulses", idx, done_cnt, 1);
      check("beats", idx, v.wr ? w_beats : r_beats, v.exp_beats);
      check("proto", idx,
            wdata_bad + wlast_bad + w_early + strb_bad + rdata_bad + rlast_bad + aw_drop, 0);
      if (v.exp_err) begin
         check("bus_idle", idx, bus_cnt, 0);
      end else begin
         check("axaddr", idx, cap_addr, v.addr);
         check("axlen", idx, cap_len, v.len);
         check("axattr", idx, cap_attr, {ID, 3'd2, 2'b01, 16'h0});
      end
   endtask

   initial begin
      int t;
      //            wr addr        len    tg dly st ebt  ers    bad bresp rbase          resp   cyc  beats err
      vecs[0]  = '{1, 32'h100, 8'd3,   0, 0, 0, -1, 2'b00, -1, 2'b00, 32'h0,          2'b00, 7,   4,   0};
      vecs[1]  = '{0, 32'h200, 8'd0,   0, 0, 0, -1, 2'b00, -1, 2'b00, 32'hDEADBEEF,   2'b00, 3,   1,   0};
      vecs[2]  = '{1, 32'h000, 8'd7,   1, 5, 0, -1, 2'b00, -1, 2'b00, 32'h0,          2'b00, 0,   8,   0};
      vecs[3]  = '{0, 32'h300, 8'd3,   0, 0, 1,  2, 2'b10, -1, 2'b00, 32'h1111_0000,  2'b10, 8,   4,   0};
      vecs[4]  = '{1, 32'hFF8, 8'd3,   0, 0, 0, -1, 2'b00, -1, 2'b00, 32'h0,          2'b10, 2,   0,   1};
      vecs[5]  = '{0, 32'hFF0, 8'd3,   0, 0, 0, -1, 2'b00, -1, 2'b00, 32'h2222_0000,  2'b00, 6,   4,   0};
      vecs[6]  = '{1, 32'h000, 8'd255, 0, 0, 0, -1, 2'b00, -1, 2'b00, 32'h0,          2'b00, 259, 256, 0};
      vecs[7]  = '{0, 32'hC04, 8'd255, 0, 0, 0, -1, 2'b00, -1, 2'b00, 32'h0,          2'b10, 2,   0,   1};
      vecs[8]  = '{0, 32'h040, 8'd2,   0, 0, 0, -1, 2'b00,  1, 2'b00, 32'h5000,       2'b10, 5,   3,   0};
      vecs[9]  = '{1, 32'h010, 8'd1,   0, 0, 0, -1, 2'b00, -1, 2'b11, 32'h0,          2'b11, 5,   2,   0};
      vecs[10] = '{0, 32'h020, 8'd1,   0, 0, 0,  0, 2'b01, -1, 2'b00, 32'h3333_0000,  2'b01, 4,   2,   0};
      vecs[11] = '{1, 32'h000, 8'd0,   0, 0, 0, -1, 2'b00, -1, 2'b00, 32'h0,          2'b00, 4,   1,   0};

      axi_resetn = 1'b0;
      cmd_valid  = 1'b0;
      cmd_write  = 1'b0;
      cmd_addr   = '0;
      cmd_len    = '0;
      repeat (3) @(negedge axi_aclk);
      check("reset_outputs", 0,
            {cmd_ready, axi_awvalid, axi_arvalid, axi_wvalid, axi_wlast, axi_bready,
             axi_rready, usr_rvalid, usr_rlast, usr_wready, done, done_resp}, 0);
      axi_resetn = 1'b1;

      for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

      // Reset in the middle of a len-7 read, while beat 2 is on the bus.
      wv_toggle = 1'b0; stall_en = 1'b0; err_beat = -1; bad_beat = -1;
      rd_base = 32'h7700_0000; cur_len = 8'd7; aw_delay = 0;
      @(negedge axi_aclk);
      mon_clr = 1'b1;
      @(negedge axi_aclk);
      mon_clr   = 1'b0;
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h400;
      cmd_len   = 8'd7;
      t = 0;
      while (!cmd_ready && t < 50) begin
         @(negedge axi_aclk);
         t++;
      end
      @(posedge axi_aclk);
      #1 cmd_valid = 1'b0;
      t = 0;
      while (r_beats != 2 && t < 100) begin
         @(negedge axi_aclk);
         t++;
      end
      check("reach_beat2", 100, r_beats, 2);
      check("beat2_valid", 100, usr_rvalid, 1);
      #2 axi_resetn = 1'b0;
      #1;
      check("async_reset_drop", 100,
            {axi_awvalid, axi_arvalid, axi_wvalid, axi_bready, axi_rready,
             usr_rvalid, usr_rlast, cmd_ready, done}, 0);
      repeat (2) @(negedge axi_aclk);
      axi_resetn = 1'b1;
      run_vec(vecs[1], 101);
      run_vec(vecs[0], 102);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
